// File: rtl/min_sopc_if.sv
//------------------------------------------------------------------------------
// min_sopc_if : instruction fetch bus between the core and the instruction ROM
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface min_sopc_if;
   logic [31:0] pc;
   logic [31:0] inst;

   modport master (output pc, input inst);
   modport slave  (input pc, output inst);
endinterface

`default_nettype wire

// File: rtl/min_sopc.sv
//------------------------------------------------------------------------------
// min_sopc : 5-stage MIPS32-subset core (logic/immediate, movz/movn, HI/LO)
//            plus instruction ROM. Optional HI/LO support: MIN_SOPC_HILO_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module min_sopc_regfile (
   input  wire         clk,
   input  wire         i_we,
   input  wire  [4:0]  i_waddr,
   input  wire  [31:0] i_wdata,
   input  wire  [4:0]  i_raddr1,
   output logic [31:0] o_rdata1,
   input  wire  [4:0]  i_raddr2,
   output logic [31:0] o_rdata2
);
   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (i_we && (i_waddr != 5'd0)) begin
         regs[i_waddr] <= i_wdata;
      end
   end

   // Write-through so the WB stage needs no separate forwarding path
   always_comb begin
      o_rdata1 = regs[i_raddr1];
      if (i_raddr1 == 5'd0)                    o_rdata1 = 32'd0;
      else if (i_we && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
      o_rdata2 = regs[i_raddr2];
      if (i_raddr2 == 5'd0)                    o_rdata2 = 32'd0;
      else if (i_we && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
   end
endmodule

module min_sopc_inst_rom #(
   parameter int ROM_DEPTH = 1024
) (
   min_sopc_if.slave rom_bus
);
   logic [31:0] inst_mem [0:ROM_DEPTH-1];
   logic [9:0]  w_idx;
   wire         w_unused_pc_bits = ^{rom_bus.pc[31:12], rom_bus.pc[1:0]};

   assign w_idx = rom_bus.pc[11:2];

   always_comb begin
      rom_bus.inst = 32'd0;
      if (32'(w_idx) < ROM_DEPTH) rom_bus.inst = inst_mem[w_idx];
   end
endmodule

module min_sopc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input wire         clk,
   input wire         rst,
   min_sopc_if.master rom_bus
);
   localparam logic [5:0] c_op_special = 6'h00;
   localparam logic [5:0] c_op_ori     = 6'h0D;
   localparam logic [5:0] c_op_lui     = 6'h0F;
   localparam logic [5:0] c_fn_and     = 6'h24;
   localparam logic [5:0] c_fn_or      = 6'h25;
   localparam logic [5:0] c_fn_xor     = 6'h26;
   localparam logic [5:0] c_fn_nor     = 6'h27;
   localparam logic [5:0] c_fn_movz    = 6'h0A;
   localparam logic [5:0] c_fn_movn    = 6'h0B;
`ifdef MIN_SOPC_HILO_EN
   localparam logic [5:0] c_fn_mfhi    = 6'h10;
   localparam logic [5:0] c_fn_mthi    = 6'h11;
   localparam logic [5:0] c_fn_mflo    = 6'h12;
   localparam logic [5:0] c_fn_mtlo    = 6'h13;
`endif

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_AND  = 4'd2,
      ALU_XOR  = 4'd3,
      ALU_NOR  = 4'd4,
      ALU_MOVZ = 4'd5,
      ALU_MOVN = 4'd6,
      ALU_MFHI = 4'd7,
      ALU_MFLO = 4'd8,
      ALU_MTHI = 4'd9,
      ALU_MTLO = 4'd10
   } alu_op_t;

   logic [31:0] r_pc;
   logic [31:0] r_ifid_inst;

   logic [5:0]  w_opcode, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [15:0] w_imm;
   wire         w_unused_shamt = ^r_ifid_inst[10:6];

   alu_op_t     w_id_op;
   logic [4:0]  w_id_wd;
   logic        w_id_wreg, w_id_use_imm, w_id_zero_op1;
   logic [31:0] w_id_imm;
   logic [31:0] w_rf_rdata1, w_rf_rdata2, w_rs_val, w_rt_val;

   alu_op_t     r_idex_op;
   logic [31:0] r_idex_op1, r_idex_op2;
   logic [4:0]  r_idex_wd;
   logic        r_idex_wreg;

   logic        w_ex_wreg;
   logic [31:0] w_ex_wdata;

   logic [4:0]  r_exmem_wd, r_memwb_wd;
   logic        r_exmem_wreg, r_memwb_wreg;
   logic [31:0] r_exmem_wdata, r_memwb_wdata;

`ifdef MIN_SOPC_HILO_EN
   logic        w_ex_we_hi, w_ex_we_lo;
   logic [31:0] w_hi_fwd, w_lo_fwd;
   logic        r_exmem_we_hi, r_exmem_we_lo, r_memwb_we_hi, r_memwb_we_lo;
   logic [31:0] r_exmem_hilo, r_memwb_hilo;
   logic [31:0] r_hi, r_lo;
`endif

   assign rom_bus.pc = r_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc        <= RESET_PC;
         r_ifid_inst <= 32'd0;
      end else begin
         r_pc        <= r_pc + 32'd4;
         r_ifid_inst <= rom_bus.inst;
      end
   end

   // ---------------- ID ----------------
   assign w_opcode = r_ifid_inst[31:26];
   assign w_rs     = r_ifid_inst[25:21];
   assign w_rt     = r_ifid_inst[20:16];
   assign w_rd     = r_ifid_inst[15:11];
   assign w_imm    = r_ifid_inst[15:0];
   assign w_funct  = r_ifid_inst[5:0];

   always_comb begin
      w_id_op       = ALU_NOP;
      w_id_wd       = 5'd0;
      w_id_wreg     = 1'b0;
      w_id_use_imm  = 1'b0;
      w_id_zero_op1 = 1'b0;
      w_id_imm      = 32'd0;
      case (w_opcode)
         c_op_lui: begin
            w_id_op       = ALU_OR;
            w_id_wd       = w_rt;
            w_id_wreg     = 1'b1;
            w_id_use_imm  = 1'b1;
            w_id_zero_op1 = 1'b1;
            w_id_imm      = {w_imm, 16'h0000};
         end
         c_op_ori: begin
            w_id_op      = ALU_OR;
            w_id_wd      = w_rt;
            w_id_wreg    = 1'b1;
            w_id_use_imm = 1'b1;
            w_id_imm     = {16'h0000, w_imm};
         end
         c_op_special: begin
            w_id_wd = w_rd;
            case (w_funct)
               c_fn_and:  begin w_id_op = ALU_AND;  w_id_wreg = 1'b1; end
               c_fn_or:   begin w_id_op = ALU_OR;   w_id_wreg = 1'b1; end
               c_fn_xor:  begin w_id_op = ALU_XOR;  w_id_wreg = 1'b1; end
               c_fn_nor:  begin w_id_op = ALU_NOR;  w_id_wreg = 1'b1; end
               c_fn_movz: begin w_id_op = ALU_MOVZ; w_id_wreg = 1'b1; end
               c_fn_movn: begin w_id_op = ALU_MOVN; w_id_wreg = 1'b1; end
`ifdef MIN_SOPC_HILO_EN
               c_fn_mfhi: begin w_id_op = ALU_MFHI; w_id_wreg = 1'b1; end
               c_fn_mflo: begin w_id_op = ALU_MFLO; w_id_wreg = 1'b1; end
               c_fn_mthi: w_id_op = ALU_MTHI;
               c_fn_mtlo: w_id_op = ALU_MTLO;
`endif
               default: ;
            endcase
         end
         default: ;
      endcase
      // Dropping $0 writes here keeps them out of the forwarding paths too
      if (w_id_wd == 5'd0) w_id_wreg = 1'b0;
   end

   min_sopc_regfile regfile1 (
      .clk      (clk),
      .i_we     (r_memwb_wreg),
      .i_waddr  (r_memwb_wd),
      .i_wdata  (r_memwb_wdata),
      .i_raddr1 (w_rs),
      .o_rdata1 (w_rf_rdata1),
      .i_raddr2 (w_rt),
      .o_rdata2 (w_rf_rdata2)
   );

   assign w_rs_val = (w_ex_wreg && (r_idex_wd == w_rs))       ? w_ex_wdata    :
                     (r_exmem_wreg && (r_exmem_wd == w_rs))   ? r_exmem_wdata : w_rf_rdata1;
   assign w_rt_val = (w_ex_wreg && (r_idex_wd == w_rt))       ? w_ex_wdata    :
                     (r_exmem_wreg && (r_exmem_wd == w_rt))   ? r_exmem_wdata : w_rf_rdata2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idex_op   <= ALU_NOP;
         r_idex_op1  <= 32'd0;
         r_idex_op2  <= 32'd0;
         r_idex_wd   <= 5'd0;
         r_idex_wreg <= 1'b0;
      end else begin
         r_idex_op   <= w_id_op;
         r_idex_op1  <= w_id_zero_op1 ? 32'd0 : w_rs_val;
         r_idex_op2  <= w_id_use_imm ? w_id_imm : w_rt_val;
         r_idex_wd   <= w_id_wd;
         r_idex_wreg <= w_id_wreg;
      end
   end

   // ---------------- EX ----------------
`ifdef MIN_SOPC_HILO_EN
   assign w_hi_fwd = r_exmem_we_hi ? r_exmem_hilo : (r_memwb_we_hi ? r_memwb_hilo : r_hi);
   assign w_lo_fwd = r_exmem_we_lo ? r_exmem_hilo : (r_memwb_we_lo ? r_memwb_hilo : r_lo);
`endif

   always_comb begin
      w_ex_wreg  = r_idex_wreg;
      w_ex_wdata = 32'd0;
`ifdef MIN_SOPC_HILO_EN
      w_ex_we_hi = 1'b0;
      w_ex_we_lo = 1'b0;
`endif
      case (r_idex_op)
         ALU_OR:   w_ex_wdata = r_idex_op1 | r_idex_op2;
         ALU_AND:  w_ex_wdata = r_idex_op1 & r_idex_op2;
         ALU_XOR:  w_ex_wdata = r_idex_op1 ^ r_idex_op2;
         ALU_NOR:  w_ex_wdata = ~(r_idex_op1 | r_idex_op2);
         ALU_MOVZ: begin
            w_ex_wdata = r_idex_op1;
            w_ex_wreg  = r_idex_wreg && (r_idex_op2 == 32'd0);
         end
         ALU_MOVN: begin
            w_ex_wdata = r_idex_op1;
            w_ex_wreg  = r_idex_wreg && (r_idex_op2 != 32'd0);
         end
`ifdef MIN_SOPC_HILO_EN
         ALU_MFHI: w_ex_wdata = w_hi_fwd;
         ALU_MFLO: w_ex_wdata = w_lo_fwd;
         ALU_MTHI: w_ex_we_hi = 1'b1;
         ALU_MTLO: w_ex_we_lo = 1'b1;
`endif
         default: ;
      endcase
   end

   // ---------------- EX/MEM, MEM/WB ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exmem_wd    <= 5'd0;
         r_exmem_wreg  <= 1'b0;
         r_exmem_wdata <= 32'd0;
         r_memwb_wd    <= 5'd0;
         r_memwb_wreg  <= 1'b0;
         r_memwb_wdata <= 32'd0;
      end else begin
         r_exmem_wd    <= r_idex_wd;
         r_exmem_wreg  <= w_ex_wreg;
         r_exmem_wdata <= w_ex_wdata;
         r_memwb_wd    <= r_exmem_wd;
         r_memwb_wreg  <= r_exmem_wreg;
         r_memwb_wdata <= r_exmem_wdata;
      end
   end

`ifdef MIN_SOPC_HILO_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exmem_we_hi <= 1'b0;
         r_exmem_we_lo <= 1'b0;
         r_exmem_hilo  <= 32'd0;
         r_memwb_we_hi <= 1'b0;
         r_memwb_we_lo <= 1'b0;
         r_memwb_hilo  <= 32'd0;
         r_hi          <= 32'd0;
         r_lo          <= 32'd0;
      end else begin
         r_exmem_we_hi <= w_ex_we_hi;
         r_exmem_we_lo <= w_ex_we_lo;
         r_exmem_hilo  <= r_idex_op1;
         r_memwb_we_hi <= r_exmem_we_hi;
         r_memwb_we_lo <= r_exmem_we_lo;
         r_memwb_hilo  <= r_exmem_hilo;
         if (r_memwb_we_hi) r_hi <= r_memwb_hilo;
         if (r_memwb_we_lo) r_lo <= r_memwb_hilo;
      end
   end
`endif
endmodule

module min_sopc #(
   parameter int          ROM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input wire clk,
   input wire rst
);
   min_sopc_if rom_if ();

   min_sopc_core #(.RESET_PC(RESET_PC)) top0 (
      .clk     (clk),
      .rst     (rst),
      .rom_bus (rom_if)
   );

   min_sopc_inst_rom #(.ROM_DEPTH(ROM_DEPTH)) inst_rom0 (
      .rom_bus (rom_if)
   );
endmodule

`default_nettype wire

// File: tb/tb_min_sopc.sv
//------------------------------------------------------------------------------
// tb_min_sopc : directed + random programs checked against an ISA-level model
//------------------------------------------------------------------------------
`default_nettype none

module tb_min_sopc;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #2 clk = ~clk;

   min_sopc #(.ROM_DEPTH(1024), .RESET_PC(32'h0)) sopc (
      .clk (clk),
      .rst (rst)
   );

   min_sopc_if mon_if ();
   assign mon_if.pc   = sopc.rom_if.pc;
   assign mon_if.inst = sopc.rom_if.inst;

`ifdef MIN_SOPC_HILO_EN
   localparam bit HILO_EN = 1'b1;
`else
   localparam bit HILO_EN = 1'b0;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          e;
   logic [31:0] prog [$];
   logic [31:0] m_regs [32];
   bit          m_known [32];
   logic [31:0] m_hi, m_lo;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] fetch(input int idx);
      return (idx < prog.size()) ? prog[idx] : 32'h0;
   endfunction

   task automatic m_write(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) begin
         m_regs[r]  = v;
         m_known[r] = 1'b1;
      end
   endtask

   // Sequential ISA semantics: forwarding makes the pipeline indistinguishable from this
   task automatic m_exec(input logic [31:0] w);
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b;
      rs = w[25:21];
      rt = w[20:16];
      rd = w[15:11];
      a  = m_regs[rs];
      b  = m_regs[rt];
      case (w[31:26])
         6'h0F: m_write(rt, {w[15:0], 16'h0000});
         6'h0D: m_write(rt, a | {16'h0000, w[15:0]});
         6'h00: begin
            case (w[5:0])
               6'h24: m_write(rd, a & b);
               6'h25: m_write(rd, a | b);
               6'h26: m_write(rd, a ^ b);
               6'h27: m_write(rd, ~(a | b));
               6'h0A: if (b == 32'd0) m_write(rd, a);
               6'h0B: if (b != 32'd0) m_write(rd, a);
               6'h10: if (HILO_EN) m_write(rd, m_hi);
               6'h12: if (HILO_EN) m_write(rd, m_lo);
               6'h11: if (HILO_EN) m_hi = a;
               6'h13: if (HILO_EN) m_lo = a;
               default: ;
            endcase
         end
         default: ;
      endcase
   endtask

   task automatic check_state(input logic [31:0] exp_pc);
      chk("pc", mon_if.pc, exp_pc);
      chk("fetch", mon_if.inst, fetch(int'(exp_pc >> 2)));
      for (int r = 1; r < 32; r++) begin
         if (m_known[r]) chk($sformatf("r%0d", r), sopc.top0.regfile1.regs[r], m_regs[r]);
      end
`ifdef MIN_SOPC_HILO_EN
      chk("hi", sopc.top0.r_hi, m_hi);
      chk("lo", sopc.top0.r_lo, m_lo);
`endif
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         e++;
         @(negedge clk);
         if (e >= 5) m_exec(fetch(e - 5));
         check_state(32'(e * 4));
      end
   endtask

   task automatic build_prog();
      logic [5:0]  fn_tab [10];
      logic [31:0] w;
      logic [15:0] imm;
      int          kind, rs, rt, rd;
      fn_tab = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h0A, 6'h0B, 6'h10, 6'h12, 6'h11, 6'h13};
      prog.push_back(enc_i(6'h0F, 0, 1, 16'h0000));
      prog.push_back(enc_i(6'h0F, 0, 2, 16'hFFFF));
      prog.push_back(enc_i(6'h0F, 0, 3, 16'h0505));
      prog.push_back(enc_i(6'h0F, 0, 4, 16'h0000));
      prog.push_back(enc_r(6'h0A, 2, 1, 4));
      prog.push_back(enc_r(6'h0B, 3, 1, 4));
      prog.push_back(enc_r(6'h0B, 3, 2, 4));
      prog.push_back(enc_r(6'h0A, 2, 3, 4));
      prog.push_back(enc_r(6'h11, 0, 0, 0));
      prog.push_back(enc_r(6'h11, 2, 0, 0));
      prog.push_back(enc_r(6'h11, 3, 0, 0));
      prog.push_back(enc_r(6'h13, 3, 0, 0));
      prog.push_back(enc_r(6'h13, 2, 0, 0));
      prog.push_back(enc_r(6'h13, 0, 0, 0));
      prog.push_back(enc_r(6'h12, 0, 0, 4));
      prog.push_back(enc_i(6'h0D, 0, 8, 16'hBEEF));
      prog.push_back(enc_r(6'h11, 2, 0, 0));
      prog.push_back(enc_r(6'h10, 0, 0, 8));
      prog.push_back(enc_i(6'h0D, 0, 5, 16'h1234));
      prog.push_back(enc_r(6'h26, 5, 5, 6));
      prog.push_back(enc_r(6'h27, 0, 0, 7));
      prog.push_back(enc_i(6'h0D, 0, 0, 16'h5555));
      prog.push_back(enc_r(6'h25, 0, 0, 9));
      for (int r = 10; r <= 12; r++) prog.push_back(enc_i(6'h0D, 0, r, 16'($urandom)));
      repeat (48) begin
         kind = $urandom_range(0, 14);
         rs   = $urandom_range(0, 12);
         rt   = $urandom_range(0, 12);
         rd   = $urandom_range(0, 12);
         imm  = 16'($urandom);
         if (kind == 0)       w = enc_i(6'h0F, rs, rd, imm);
         else if (kind == 1)  w = enc_i(6'h0D, rs, rd, imm);
         else if (kind <= 11) w = enc_r(fn_tab[kind-2], rs, rt, rd);
         else if (kind == 12) w = 32'h0;
         else if (kind == 13) begin
            w = $urandom();
            w[31:26] = 6'h08;
         end else             w = enc_r(6'h20, rs, rt, rd);
         prog.push_back(w);
      end
   endtask

   initial begin
      build_prog();
      for (int i = 0; i < 1024; i++) begin
         sopc.inst_rom0.inst_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
      end
      for (int r = 0; r < 32; r++) begin
         m_regs[r]  = 'x;
         m_known[r] = 1'b0;
      end
      m_regs[0] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      e    = 0;

      repeat (2) @(negedge clk);
      check_state(32'h0);
      rst = 1'b1;
      run_cycles(40);

      // Mid-program reset: checked before the next rising edge to see the async clear
      rst = 1'b0;
      #1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      e    = 0;
      check_state(32'h0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_state(32'h0);
      end
      rst = 1'b1;
      run_cycles(prog.size() + 8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
